tile_rom_server: RTL and testbench

TILE_ROM_SERVER -- requirements
Module: tile_rom_server

---
 rtl/tile_rom_server_pkg.sv | 14 +
 rtl/tile_rom_server_mem.sv | 22 ++
 rtl/tile_rom_server.sv | 100 ++++++++++
 tb/tb_tile_rom_server.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/tile_rom_server_pkg.sv
// Shared constants and FSM encoding for the tile ROM server.
package tile_rom_server_pkg;

    localparam int MEM_DEPTH    = 256;
    localparam int ADDR_W       = 8;
    localparam int PIX_W        = 3;
    localparam int READ_LATENCY = 2;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/tile_rom_server_mem.sv
// 256x3 pixel store: one write port, one asynchronous read port with write-through bypass.
module tile_mem
    import tile_rom_server_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [PIX_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [PIX_W-1:0]  o_rdata
);

    logic [PIX_W-1:0] r_mem [MEM_DEPTH];

    // No reset on the array: contents survive reset and are rewritten by INIT.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/tile_rom_server.sv
// Tile pixel server: INIT fills memory with k[2:0], SERVE answers reads with 2-cycle latency.
module tile_rom_server
    import tile_rom_server_pkg::*;
(
    input  logic              vgaclk,
    input  logic              reset,
    input  logic              pixelEN,
    input  logic [ADDR_W-1:0] addr,
    input  logic              inv,
    output logic              romEN,
    output logic              r,
    output logic              g,
    output logic              b,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [PIX_W-1:0]  ld_data,
    output logic              init_done
);

    state_t                  r_state, w_state_nxt;
    logic [ADDR_W-1:0]       r_cnt;
    logic [READ_LATENCY-1:0] r_vld;
    logic [ADDR_W-1:0]       r_s1_addr;
    logic                    r_s1_inv;
    logic                    r_s1_init;
    logic [PIX_W-1:0]        r_rgb;

    logic                    w_we;
    logic [ADDR_W-1:0]       w_waddr;
    logic [PIX_W-1:0]        w_wdata;
    logic [PIX_W-1:0]        w_rdata;
    logic                    w_ld_ready;

    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
        end
    end

    // INIT owns the write port; loader writes only in SERVE and only on idle pixel cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_ready  = 1'b0;
        w_we        = 1'b0;
        w_waddr     = ld_addr;
        w_wdata     = ld_data;
        case (r_state)
            ST_INIT: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_wdata = r_cnt[PIX_W-1:0];
                if (r_cnt == ADDR_W'(MEM_DEPTH - 1)) w_state_nxt = ST_SERVE;
            end
            ST_SERVE: begin
                w_ld_ready = ~pixelEN;
                w_we       = ld_valid & ~pixelEN;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    tile_mem u_mem (
        .i_clk   (vgaclk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_s1_addr),
        .o_rdata (w_rdata)
    );

    // r_vld[0] = stage 1 holds a request, r_vld[LAT-1] = romEN.
    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            r_vld     <= '0;
            r_s1_addr <= '0;
            r_s1_inv  <= 1'b0;
            r_s1_init <= 1'b0;
            r_rgb     <= '0;
        end else begin
            r_vld <= {r_vld[READ_LATENCY-2:0], pixelEN};
            if (pixelEN) begin
                r_s1_addr <= addr;
                r_s1_inv  <= inv;
                r_s1_init <= (r_state == ST_INIT);
            end
            if (r_vld[0]) r_rgb <= r_s1_init ? '0 : (w_rdata ^ {PIX_W{r_s1_inv}});
        end
    end

    assign romEN     = r_vld[READ_LATENCY-1];
    assign {r, g, b} = r_rgb;
    assign ld_ready  = w_ld_ready;
    assign init_done = (r_state == ST_SERVE);

endmodule

// File: tb/tb_tile_rom_server.sv
// Directed bench for tile_rom_server: init timing, reads, loader writes, bypass, reset abort.
module tb_tile_rom_server;

    logic       vgaclk = 1'b0;
    logic       reset;
    logic       pixelEN;
    logic [7:0] addr;
    logic       inv;
    logic       romEN, r, g, b;
    logic       ld_valid, ld_ready;
    logic [7:0] ld_addr;
    logic [2:0] ld_data;
    logic       init_done;

    int checks   = 0;
    int failures = 0;

    tile_rom_server dut (
        .vgaclk    (vgaclk),
        .reset     (reset),
        .pixelEN   (pixelEN),
        .addr      (addr),
        .inv       (inv),
        .romEN     (romEN),
        .r         (r),
        .g         (g),
        .b         (b),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .init_done (init_done)
    );

    always #5 vgaclk = ~vgaclk;

    task automatic step();
        @(negedge vgaclk);
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one read and check the 2-cycle response.
    task automatic do_read(input string tag, input logic [7:0] a, input logic i, input logic [2:0] exp);
        pixelEN = 1'b1; addr = a; inv = i;
        step();
        pixelEN = 1'b0;
        check({tag, "_lat1_romEN"}, {7'd0, romEN}, 8'd0);
        step();
        check({tag, "_romEN"}, {7'd0, romEN}, 8'd1);
        check({tag, "_rgb"}, {5'd0, r, g, b}, {5'd0, exp});
        step();
        check({tag, "_after_romEN"}, {7'd0, romEN}, 8'd0);
        check({tag, "_hold_rgb"}, {5'd0, r, g, b}, {5'd0, exp});
    endtask

    initial begin
        reset = 1'b0; pixelEN = 1'b0; addr = '0; inv = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) step();
        check("rst_romEN", {7'd0, romEN}, 8'd0);
        check("rst_rgb", {5'd0, r, g, b}, 8'd0);
        check("rst_ld_ready", {7'd0, ld_ready}, 8'd0);
        check("rst_init_done", {7'd0, init_done}, 8'd0);

        // Release, count edges; a read issued during INIT returns 000.
        reset = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (k == 10) begin
                pixelEN = 1'b1; addr = 8'h05; inv = 1'b1;
            end else begin
                pixelEN = 1'b0;
            end
            if (k == 11) check("init_rd_lat1", {7'd0, romEN}, 8'd0);
            if (k == 12) begin
                check("init_rd_romEN", {7'd0, romEN}, 8'd1);
                check("init_rd_rgb", {5'd0, r, g, b}, 8'd0);
            end
            if (k == 100) check("init_ld_ready", {7'd0, ld_ready}, 8'd0);
            if (k == 255) check("init_done_255", {7'd0, init_done}, 8'd0);
            if (k == 256) check("init_done_256", {7'd0, init_done}, 8'd1);
        end
        check("serve_ld_ready", {7'd0, ld_ready}, 8'd1);

        do_read("rd0D", 8'h0D, 1'b0, 3'b101);
        do_read("rd0D_inv", 8'h0D, 1'b1, 3'b010);

        // Loader write collides with a read: read wins, write lands next idle cycle.
        pixelEN = 1'b1; addr = 8'h01; inv = 1'b0;
        ld_valid = 1'b1; ld_addr = 8'h40; ld_data = 3'b110;
        #1 check("ld_ready_blocked", {7'd0, ld_ready}, 8'd0);
        step();
        pixelEN = 1'b0;
        #1 check("ld_ready_idle", {7'd0, ld_ready}, 8'd1);
        step();
        ld_valid = 1'b0;
        check("collide_rd_romEN", {7'd0, romEN}, 8'd1);
        check("collide_rd_rgb", {5'd0, r, g, b}, 8'd1);
        do_read("rd40", 8'h40, 1'b0, 3'b110);

        // Write in the same cycle the read sits in stage 2 must bypass.
        pixelEN = 1'b1; addr = 8'h41; inv = 1'b0;
        step();
        pixelEN = 1'b0;
        ld_valid = 1'b1; ld_addr = 8'h41; ld_data = 3'b111;
        step();
        ld_valid = 1'b0;
        check("bypass_romEN", {7'd0, romEN}, 8'd1);
        check("bypass_rgb", {5'd0, r, g, b}, 8'd7);

        // Back-to-back reads at full throughput.
        pixelEN = 1'b1; addr = 8'h01; step();
        addr = 8'h02; step();
        check("b2b_romEN1", {7'd0, romEN}, 8'd1);
        check("b2b_rgb1", {5'd0, r, g, b}, 8'd1);
        addr = 8'h03; step();
        check("b2b_romEN2", {7'd0, romEN}, 8'd1);
        check("b2b_rgb2", {5'd0, r, g, b}, 8'd2);
        addr = 8'h04; step();
        check("b2b_romEN3", {7'd0, romEN}, 8'd1);
        check("b2b_rgb3", {5'd0, r, g, b}, 8'd3);
        pixelEN = 1'b0; step();
        check("b2b_romEN4", {7'd0, romEN}, 8'd1);
        check("b2b_rgb4", {5'd0, r, g, b}, 8'd4);
        step();
        check("b2b_end_romEN", {7'd0, romEN}, 8'd0);

        // Reset one cycle after a request aborts it and restarts INIT.
        pixelEN = 1'b1; addr = 8'h03; step();
        pixelEN = 1'b0; reset = 1'b0;
        #1 check("abort_init_done", {7'd0, init_done}, 8'd0);
        step();
        check("abort_romEN1", {7'd0, romEN}, 8'd0);
        step();
        check("abort_romEN2", {7'd0, romEN}, 8'd0);
        check("abort_rgb", {5'd0, r, g, b}, 8'd0);
        reset = 1'b1;
        repeat (255) step();
        check("reinit_done_255", {7'd0, init_done}, 8'd0);
        step();
        check("reinit_done_256", {7'd0, init_done}, 8'd1);
        do_read("rd40_reinit", 8'h40, 1'b0, 3'b000);
        do_read("rd0D_reinit", 8'h0D, 1'b0, 3'b101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
